// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
// Holds the control-state enum, display anode patterns and the BCD digit type.
// No logic; imported by stopwatch_core and its sub-modules.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  // Four-digit SS.CC value, most significant digit first.
  typedef struct packed {
    bcd_t s_t;
    bcd_t s_o;
    bcd_t c_t;
    bcd_t c_o;
  } sw_count_t;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;

  localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/stopwatch_core_tick_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports: clk, rst (async, active-high), async_in (any domain), pulse_out
// (one clk wide, high in the cycle after the second sync flop first sees a 1).
module tick_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse_out
);

  logic sync_0;
  logic sync_1;
  logic sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_0    <= async_in;
      sync_1    <= sync_0;
      sync_prev <= sync_1;
    end
  end

  // Fires when the synchronized level has just gone high.
  assign pulse_out = sync_1 & ~sync_prev;

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: SS.CC BCD counter with start/stop, lap and clear,
// driving a 4-digit multiplexed display (active-low anodes, BCD digit, dp_n).
// Ports: clk, rst (async high), tick_100 (async 100 Hz), scan_sel[1:0],
// start_stop/lap/clear pulses; an[3:0], bcd_out[3:0], dp_n, running,
// lap_active, overflow (sticky wrap flag).
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100,
  input  logic [1:0] scan_sel,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] an,
  output logic [3:0] bcd_out,
  output logic       dp_n,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam bcd_t SEC_T = bcd_t'(SEC_MAX / 10);
  localparam bcd_t SEC_O = bcd_t'(SEC_MAX % 10);

  logic      tick_en;
  sw_state_t state, state_nxt;
  sw_count_t count, count_nxt;
  sw_count_t lap_reg, lap_nxt;
  sw_count_t disp_val;
  logic      overflow_nxt;
  logic      do_inc;

  tick_edge_sync u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (tick_100),
    .pulse_out(tick_en)
  );

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // clear > start_stop > lap; a lower-priority pulse in the same cycle is dropped.
  always_comb begin
    state_nxt = state;
    lap_nxt   = lap_reg;
    if (clear) begin
      state_nxt = IDLE;
      lap_nxt   = '0;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        LAP:     state_nxt = PAUSE;
        default: state_nxt = IDLE;
      endcase
    end else if (lap) begin
      case (state)
        RUN: begin
          state_nxt = LAP;
          lap_nxt   = count;  // freeze the pre-edge live value
        end
        LAP:     state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  assign running    = (state == RUN) || (state == LAP);
  assign lap_active = (state == LAP);

  // ---------------- BCD counter ----------------
  // Increment decision uses the pre-edge state, so a start_stop that pauses
  // still lets a coincident tick count, and one that resumes does not.
  assign do_inc = tick_en && running;

  always_comb begin
    count_nxt    = count;
    overflow_nxt = overflow;
    if (do_inc) begin
      if (count.c_o != BCD_NINE) begin
        count_nxt.c_o = count.c_o + 4'd1;
      end else begin
        count_nxt.c_o = '0;
        if (count.c_t != BCD_NINE) begin
          count_nxt.c_t = count.c_t + 4'd1;
        end else begin
          count_nxt.c_t = '0;
          if (count.s_t == SEC_T && count.s_o == SEC_O) begin
            count_nxt.s_t = '0;
            count_nxt.s_o = '0;
            overflow_nxt  = 1'b1;
          end else if (count.s_o != BCD_NINE) begin
            count_nxt.s_o = count.s_o + 4'd1;
          end else begin
            count_nxt.s_o = '0;
            count_nxt.s_t = count.s_t + 4'd1;
          end
        end
      end
    end
    if (clear) begin
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      lap_reg  <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      lap_reg  <= lap_nxt;
      overflow <= overflow_nxt;
    end
  end

  // ---------------- display scan ----------------
  assign disp_val = (state == LAP) ? lap_reg : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= AN_OFF;
      bcd_out <= '0;
      dp_n    <= 1'b1;
    end else begin
      dp_n <= 1'b1;
      case (scan_sel)
        2'd0: begin
          an      <= AN_D0;
          bcd_out <= disp_val.c_o;
        end
        2'd1: begin
          an      <= AN_D1;
          bcd_out <= disp_val.c_t;
        end
        2'd2: begin
          an      <= AN_D2;
          bcd_out <= disp_val.s_o;
          dp_n    <= 1'b0;
        end
        default: begin
          an      <= AN_D3;
          bcd_out <= disp_val.s_t;
        end
      endcase
    end
  end

endmodule
